// File: rtl/lb_pkg.sv
// Shared types, widths and default geometry for the
// line window controller and its position counter.
package lb_pkg;

  typedef logic [1:0] lb_state_e;

  localparam lb_state_e IDLE = 2'd0;
  localparam lb_state_e FILL = 2'd1;
  localparam lb_state_e RUN  = 2'd2;
  localparam lb_state_e DONE = 2'd3;

  localparam int DEF_IMG_WIDTH  = 800;
  localparam int DEF_IMG_HEIGHT = 600;
  localparam int DEF_NUM_TAPS   = 24;
  localparam int DEF_DATA_W     = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CW = cnt_w(DEF_IMG_WIDTH);
  localparam int DEF_RW = cnt_w(DEF_IMG_HEIGHT);

endpackage

// File: rtl/lb_pos_counter.sv
// Column/row raster position of the pixel being accepted,
// with restart-at-origin, sync clear and wrap/last flags.
module lb_pos_counter
  import lb_pkg::*;
#(
  parameter int WIDTH  = DEF_IMG_WIDTH,
  parameter int HEIGHT = DEF_IMG_HEIGHT,
  localparam int CW    = cnt_w(WIDTH),
  localparam int RW    = cnt_w(HEIGHT)
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          restart_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          col_wrap_o,
  output logic          row_last_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;

  // A restart makes the current pixel the frame origin.
  assign col_o = restart_i ? '0 : col_q;
  assign row_o = restart_i ? '0 : row_q;

  assign col_wrap_o = (col_o == COL_MAX);
  assign row_last_o = (row_o == ROW_MAX);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_wrap_o) begin
        col_d = '0;
        row_d = row_last_o ? row_o
                           : row_o + RW'(1);
      end else begin
        col_d = col_o + CW'(1);
        row_d = row_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    col_q <= col_d;
    row_q <= row_d;
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Line buffer sequencer: gates shifts from the input handshake
// and flags each complete vertical window to the filter stage.
module line_window_ctrl
  import lb_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int DATA_W     = DEF_DATA_W,
  localparam int CW        = cnt_w(IMG_WIDTH),
  localparam int RW        = cnt_w(IMG_HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              lb_clken,
  output logic [DATA_W-1:0] lb_shiftin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_col,
  output logic [RW-1:0]     out_row,
  output logic              out_sof,
  output logic              out_eol,
  output logic              frame_done,
  output logic              err_sof
);

  localparam logic [RW-1:0] FILL_ROW = RW'(NUM_TAPS - 2);
  localparam logic [RW-1:0] WIN_ROW  = RW'(NUM_TAPS - 1);

  lb_state_e     state_q;
  lb_state_e     state_d;
  lb_state_e     eff_state;
  logic          valid_q;
  logic          valid_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic          sof_q;
  logic          sof_d;
  logic          eol_q;
  logic          eol_d;
  logic          err_q;
  logic          err_d;

  logic          acc;
  logic          take;
  logic          restart;
  logic          pos_clr;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          col_wrap;
  logic          row_last;

  // Never shift while a window is held unconsumed.
  assign in_ready = (state_q != DONE)
                  & (~valid_q | out_ready);

  assign acc     = in_valid & in_ready;
  assign take    = acc & ((state_q != IDLE) | in_sof);
  assign restart = take & in_sof;
  assign pos_clr = reset | (state_q == DONE);

  assign lb_clken   = take;
  assign lb_shiftin = in_data;

  assign eff_state = restart ? FILL : state_q;

  lb_pos_counter #(
    .WIDTH     (IMG_WIDTH),
    .HEIGHT    (IMG_HEIGHT)
  ) u_pos (
    .clk_i     (clock),
    .clr_i     (pos_clr),
    .en_i      (take),
    .restart_i (restart),
    .col_o     (cur_col),
    .row_o     (cur_row),
    .col_wrap_o(col_wrap),
    .row_last_o(row_last)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    col_d   = col_q;
    row_d   = row_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    err_d   = 1'b0;
    if (take) begin
      err_d = in_sof & (state_q != IDLE);
      unique case (1'b1)
        (eff_state == FILL): begin
          valid_d = 1'b0;
          if ((cur_row == FILL_ROW) && col_wrap)
            state_d = RUN;
          else
            state_d = FILL;
        end
        (eff_state == RUN): begin
          valid_d = 1'b1;
          col_d   = cur_col;
          row_d   = cur_row;
          sof_d   = (cur_row == WIN_ROW)
                  & (cur_col == '0);
          eol_d   = col_wrap;
          if (row_last && col_wrap)
            state_d = DONE;
          else
            state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      if (out_ready)
        valid_d = 1'b0;
      if (state_q == DONE)
        state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_col    = col_q;
  assign out_row    = row_q;
  assign out_sof    = sof_q;
  assign out_eol    = eol_q;
  assign frame_done = (state_q == DONE);
  assign err_sof    = err_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed plus randomized bench for line_window_ctrl with a
// tap-distance line buffer model and a frame-level reference.
module tb_line_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 30;
  localparam int NT   = 24;
  localparam int DW   = 8;
  localparam int CW   = $clog2(W);
  localparam int RW   = $clog2(H);
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          lb_clken;
  logic [DW-1:0] lb_shiftin;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;
  logic          err_sof;

  int checks = 0;
  int errors = 0;

  // frame-level reference: linear pixel index within the frame
  bit            m_active, m_valid, m_sof, m_eol, m_done, m_err;
  int            m_pos, m_col, m_row;
  logic [DW-1:0] img [NPIX];
  logic [DW-1:0] lbq [$];

  int            src_idx;
  logic [DW-1:0] src_data;
  bit            src_on, rnd_valid, rnd_ready, hold_ready;
  int            windows, frames, errs, sof_cnt, sof_at, shifts;

  line_window_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .NUM_TAPS  (NT),
    .DATA_W    (DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .lb_clken  (lb_clken),
    .lb_shiftin(lb_shiftin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done),
    .err_sof   (err_sof)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit exp_rdy, acc, take, nd, ne;
    int r, c, bad, orow, ocol;
    in_sof   = src_on && (src_idx == 0);
    in_data  = src_data;
    in_valid = src_on &&
               (rnd_valid ? 1'($urandom_range(1)) : 1'b1);
    out_ready = !hold_ready &&
               (rnd_ready ? 1'($urandom_range(1)) : 1'b1);
    #1;
    exp_rdy = !m_done && (!m_valid || out_ready);
    acc  = in_valid && exp_rdy;
    take = acc && (m_active || in_sof);
    chk("in_ready", in_ready, exp_rdy);
    chk("lb_clken", lb_clken, take);
    if (take) chk("lb_shiftin", lb_shiftin, in_data);
    if (out_valid === 1'b1 && out_ready) begin
      windows++;
      if (out_sof === 1'b1) sof_cnt++;
      orow = int'(out_row);
      ocol = int'(out_col);
      bad = 0;
      for (int k = 0; k < NT; k++) begin
        if (orow - k < 0 || lbq.size() <= k * W)
          bad++;
        else if (lbq[k*W] !== img[(orow-k)*W+ocol])
          bad++;
      end
      chk("window_col", bad, 0);
    end
    if (lb_clken === 1'b1) begin
      shifts++;
      lbq.push_front(lb_shiftin);
      if (lbq.size() > NT * W) void'(lbq.pop_back());
    end
    nd = 0;
    ne = 0;
    if (take) begin
      if (in_sof) begin
        ne = m_active;
        m_pos = 0;
      end else begin
        m_pos++;
      end
      img[m_pos] = in_data;
      r = m_pos / W;
      c = m_pos % W;
      if (r >= NT - 1) begin
        m_valid = 1;
        m_row = r;
        m_col = c;
        m_sof = (r == NT - 1) && (c == 0);
        m_eol = (c == W - 1);
      end else begin
        m_valid = 0;
      end
      if (m_pos == NPIX - 1) begin
        m_active = 0;
        nd = 1;
      end else begin
        m_active = 1;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (acc) begin
      src_idx  = (src_idx + 1) % NPIX;
      src_data = DW'($urandom);
    end
    @(posedge clock);
    #1;
    m_done = nd;
    m_err  = ne;
    if (nd) frames++;
    if (ne) errs++;
    chk("out_valid", out_valid, m_valid);
    chk("frame_done", frame_done, m_done);
    chk("err_sof", err_sof, m_err);
    if (m_valid) begin
      chk("out_col", out_col, m_col);
      chk("out_row", out_row, m_row);
      chk("out_sof", out_sof, m_sof);
      chk("out_eol", out_eol, m_eol);
      if (m_sof && sof_at < 0) sof_at = m_pos;
    end
  endtask

  task automatic do_reset();
    src_on    = 0;
    in_valid  = 0;
    in_sof    = 0;
    in_data   = '0;
    out_ready = 0;
    reset     = 1;
    @(posedge clock);
    #1;
    reset    = 0;
    m_active = 0;
    m_valid  = 0;
    m_done   = 0;
    m_err    = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_sof", err_sof, 0);
    chk("rst_lb_clken", lb_clken, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic start_test();
    windows = 0;
    frames  = 0;
    errs    = 0;
    sof_cnt = 0;
    sof_at  = -1;
    src_on  = 1;
  endtask

  task automatic run_frames(input int n, input int budget);
    int cnt = 0;
    while (frames < n && cnt < budget) begin
      cycle();
      cnt++;
    end
    chk("frame_timeout", frames, n);
    src_on = 0;
    cnt = 0;
    while (m_valid && cnt < 64) begin
      cycle();
      cnt++;
    end
    cycle();
  endtask

  task automatic run_to_pos(input int p, input int budget);
    int cnt = 0;
    while (!(m_active && m_pos == p) && cnt < budget) begin
      cycle();
      cnt++;
    end
    chk("pos_timeout", m_pos, p);
  endtask

  initial begin
    int hc, hr;
    src_idx    = 0;
    src_data   = DW'($urandom);
    rnd_valid  = 0;
    rnd_ready  = 0;
    hold_ready = 0;
    m_pos      = 0;
    m_col      = 0;
    m_row      = 0;
    m_sof      = 0;
    m_eol      = 0;
    start_test();
    do_reset();

    // non-sof pixels while idle are dropped
    start_test();
    src_idx = 5;
    shifts  = 0;
    repeat (5) cycle();
    chk("idle_shifts", shifts, 0);
    chk("idle_valid", out_valid, 0);
    src_on  = 0;
    src_idx = 0;
    cycle();

    // full frame, no stalls
    start_test();
    run_frames(1, 400);
    chk("f1_windows", windows, 56);
    chk("f1_sof_cnt", sof_cnt, 1);
    chk("f1_sof_at", sof_at, 184);

    // downstream stall mid-RUN
    start_test();
    run_to_pos(200, 400);
    hc = m_col;
    hr = m_row;
    hold_ready = 1;
    shifts = 0;
    repeat (4) cycle();
    chk("hold_shifts", shifts, 0);
    chk("hold_col", out_col, hc);
    chk("hold_row", out_row, hr);
    hold_ready = 0;
    run_frames(1, 400);
    chk("f3_windows", windows, 56);

    // stray sof at row 10 col 3
    start_test();
    run_to_pos(82, 400);
    src_idx = 0;
    run_frames(1, 400);
    chk("f4_errs", errs, 1);
    chk("f4_windows", windows, 56);
    chk("f4_sof_at", sof_at, 184);

    // reset inside row 25
    start_test();
    run_to_pos(205, 400);
    do_reset();
    start_test();
    src_idx = 0;
    run_frames(1, 400);
    chk("f5_windows", windows, 56);

    // randomized handshakes over three frames
    start_test();
    rnd_valid = 1;
    rnd_ready = 1;
    run_frames(3, 6000);
    chk("f6_windows", windows, 168);
    chk("f6_sof_cnt", sof_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
